// File: rtl/fb_arbiter.sv
// fb_arbiter
// Shares one single-port 640x480x2-bit framebuffer SRAM between the VGA
// scanout path and the drawing side. Display fetches always win the slot.
// Any free slot is shared round-robin between NREQ drawing requesters and a
// built-in frame-clear engine, which contends as requester index NREQ.
//
// Ports
//   CLOCK_50, nReset          clock, asynchronous active-low reset
//   disp_strobe, pixel_x/y    display fetch request and pixel coordinate
//   pixel                     registered display pixel
//   req_valid/we/addr/wdata   per-requester access (addr 19 bits, data 2 bits each)
//   req_ready                 combinational grant
//   rsp_valid, rsp_data       read response, one cycle after a read grant
//   clear_start, clear_color  start a full-frame fill with the given color
//   clear_busy                fill in progress
//   mem_en/we/addr/wdata      SRAM command, combinational from the slot decision
//   mem_rdata                 SRAM read data, one cycle after a read command
module fb_arbiter #(
    parameter int NREQ     = 2,
    parameter int FB_DEPTH = 307200
) (
    input  logic                 CLOCK_50,
    input  logic                 nReset,
    input  logic                 disp_strobe,
    input  logic [9:0]           pixel_x,
    input  logic [8:0]           pixel_y,
    output logic [1:0]           pixel,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ-1:0]      req_we,
    input  logic [NREQ*19-1:0]   req_addr,
    input  logic [NREQ*2-1:0]    req_wdata,
    output logic [NREQ-1:0]      req_ready,
    output logic [NREQ-1:0]      rsp_valid,
    output logic [1:0]           rsp_data,
    input  logic                 clear_start,
    input  logic [1:0]           clear_color,
    output logic                 clear_busy,
    output logic                 mem_en,
    output logic                 mem_we,
    output logic [18:0]          mem_addr,
    output logic [1:0]           mem_wdata,
    input  logic [1:0]           mem_rdata
);

    localparam int NC = NREQ + 1;
    localparam int PW = $clog2(NC);
    localparam logic [18:0] DEPTH = 19'(FB_DEPTH);
    localparam logic [18:0] LAST  = 19'(FB_DEPTH - 1);

    typedef enum logic {IDLE, FILL} clr_state_t;

    clr_state_t        state, state_next;
    logic [18:0]       clr_addr, clr_addr_next;
    logic [1:0]        clr_color, clr_color_next;
    logic              clr_write;

    logic [PW-1:0]     rr_ptr, rr_ptr_next;
    logic [NC-1:0]     contend;
    logic              grant_any;
    logic [PW-1:0]     grant_idx;
    logic [PW-1:0]     cand;

    logic              disp_pend;
    logic [NREQ-1:0]   rsp_pend, rsp_pend_next;
    logic              rsp_in_range, rsp_in_range_next;
    logic [18:0]       disp_addr;

    // y*640 + x as two shifts and adds; fits 19 bits for legal coordinates
    assign disp_addr = 19'({pixel_y, 9'b0}) + 19'({pixel_y, 7'b0}) + 19'(pixel_x);

    assign clear_busy = (state == FILL);

    // A display strobe takes the slot, so nobody contends in that cycle
    assign contend = disp_strobe ? '0 : {clear_busy, req_valid};

    // Round-robin search starting at the pointer, wrapping over NREQ+1 slots
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = 0; k < NC; k++) begin
            cand = PW'((int'(rr_ptr) + k) % NC);
            if (!grant_any && contend[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
        end
    end

    // Pointer moves to one past the winner only when someone was granted
    always_comb begin
        rr_ptr_next = rr_ptr;
        if (grant_any) begin
            rr_ptr_next = (grant_idx == PW'(NREQ)) ? '0 : grant_idx + PW'(1);
        end
    end

    // Slot decision driving the SRAM command, grants and pending responses.
    // Everything is gated by nReset so the outputs sit at zero during reset.
    // Out-of-range requests are granted but never reach the SRAM.
    always_comb begin
        req_ready         = '0;
        mem_en            = 1'b0;
        mem_we            = 1'b0;
        mem_addr          = '0;
        mem_wdata         = '0;
        rsp_pend_next     = '0;
        rsp_in_range_next = 1'b0;
        clr_write         = 1'b0;
        if (nReset) begin
            if (disp_strobe) begin
                mem_en   = 1'b1;
                mem_addr = disp_addr;
            end else if (grant_any) begin
                if (grant_idx == PW'(NREQ)) begin
                    clr_write = 1'b1;
                    mem_en    = 1'b1;
                    mem_we    = 1'b1;
                    mem_addr  = clr_addr;
                    mem_wdata = clr_color;
                end else begin
                    for (int i = 0; i < NREQ; i++) begin
                        if (grant_idx == PW'(i)) begin
                            req_ready[i +: 1] = 1'b1;
                            if (req_addr[19*i +: 19] < DEPTH) begin
                                mem_en            = 1'b1;
                                mem_we            = req_we[i +: 1];
                                mem_addr          = req_addr[19*i +: 19];
                                mem_wdata         = req_wdata[2*i +: 2];
                                rsp_in_range_next = 1'b1;
                            end
                            if (!req_we[i +: 1]) begin
                                rsp_pend_next[i +: 1] = 1'b1;
                            end
                        end
                    end
                end
            end
        end
    end

    // Clear engine: a start in IDLE latches the color and rewinds the
    // counter; each clear grant writes one pixel, the last one ends the fill
    always_comb begin
        state_next     = state;
        clr_addr_next  = clr_addr;
        clr_color_next = clr_color;
        case (state)
            IDLE: begin
                if (clear_start) begin
                    state_next     = FILL;
                    clr_addr_next  = '0;
                    clr_color_next = clear_color;
                end
            end
            FILL: begin
                if (clr_write) begin
                    if (clr_addr == LAST) begin
                        state_next = IDLE;
                    end else begin
                        clr_addr_next = clr_addr + 19'd1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Clear engine state register
    always_ff @(posedge CLOCK_50 or negedge nReset) begin
        if (!nReset) begin
            state     <= IDLE;
            clr_addr  <= '0;
            clr_color <= '0;
        end else begin
            state     <= state_next;
            clr_addr  <= clr_addr_next;
            clr_color <= clr_color_next;
        end
    end

    // Arbiter pointer, pending display/response flags and the pixel register
    always_ff @(posedge CLOCK_50 or negedge nReset) begin
        if (!nReset) begin
            rr_ptr       <= '0;
            disp_pend    <= 1'b0;
            rsp_pend     <= '0;
            rsp_in_range <= 1'b0;
            pixel        <= '0;
        end else begin
            rr_ptr       <= rr_ptr_next;
            disp_pend    <= disp_strobe;
            rsp_pend     <= rsp_pend_next;
            rsp_in_range <= rsp_in_range_next;
            if (disp_pend) begin
                pixel <= mem_rdata;
            end
        end
    end

    // Response data is the SRAM output, or zero for an out-of-range read
    assign rsp_valid = rsp_pend;
    assign rsp_data  = (|rsp_pend && rsp_in_range) ? mem_rdata : 2'b00;

endmodule

// File: tb/tb_fb_arbiter.sv
// tb_fb_arbiter
// Directed and randomized checks of fb_arbiter against a slot-level model
// of the arbitration rules. A shortened frame keeps full clear sweeps short.
module tb_fb_arbiter;

    localparam int NREQ  = 2;
    localparam int DEPTH = 1000;
    localparam int NC    = NREQ + 1;

    logic                 clk = 1'b0;
    logic                 nReset;
    logic                 disp_strobe;
    logic [9:0]           pixel_x;
    logic [8:0]           pixel_y;
    logic [1:0]           pixel;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_we;
    logic [NREQ*19-1:0]   req_addr;
    logic [NREQ*2-1:0]    req_wdata;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ-1:0]      rsp_valid;
    logic [1:0]           rsp_data;
    logic                 clear_start;
    logic [1:0]           clear_color;
    logic                 clear_busy;
    logic                 mem_en;
    logic                 mem_we;
    logic [18:0]          mem_addr;
    logic [1:0]           mem_wdata;
    logic [1:0]           mem_rdata;

    fb_arbiter #(.NREQ(NREQ), .FB_DEPTH(DEPTH)) dut (
        .CLOCK_50    (clk),
        .nReset      (nReset),
        .disp_strobe (disp_strobe),
        .pixel_x     (pixel_x),
        .pixel_y     (pixel_y),
        .pixel       (pixel),
        .req_valid   (req_valid),
        .req_we      (req_we),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_ready   (req_ready),
        .rsp_valid   (rsp_valid),
        .rsp_data    (rsp_data),
        .clear_start (clear_start),
        .clear_color (clear_color),
        .clear_busy  (clear_busy),
        .mem_en      (mem_en),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int               m_ptr;
    bit               m_busy;
    int               m_cnt;
    logic [1:0]       m_color;
    bit               m_disp_pend;
    logic [1:0]       m_pix;
    logic [NREQ-1:0]  m_rsp;
    bit               m_rsp_inr;
    int               m_gi;
    bit               m_inr;
    logic [NREQ-1:0]  m_gnt;

    int writes;
    int last_addr;
    int guard;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        m_ptr = 0; m_busy = 0; m_cnt = 0; m_color = '0;
        m_disp_pend = 0; m_pix = '0; m_rsp = '0; m_rsp_inr = 0;
        m_gi = -1; m_inr = 0; m_gnt = '0;
    endtask

    task automatic setIdle();
        disp_strobe = 0; pixel_x = '0; pixel_y = '0;
        req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
        clear_start = 0; clear_color = '0; mem_rdata = '0;
    endtask

    // Predict the slot outcome for the current inputs and compare everything
    task automatic checkOutput();
        logic [NREQ-1:0] e_ready;
        logic            e_en, e_we;
        logic [18:0]     e_addr, a;
        logic [1:0]      e_wd;
        int              c;
        @(negedge clk);
        e_ready = '0; e_en = 0; e_we = 0; e_addr = '0; e_wd = '0;
        m_gi = -1; m_inr = 0;
        if (disp_strobe) begin
            e_en = 1;
            e_addr = 19'(int'(pixel_y) * 640 + int'(pixel_x));
        end else begin
            for (int k = 0; k < NC; k++) begin
                c = (m_ptr + k) % NC;
                if (m_gi < 0 && ((c < NREQ) ? req_valid[c +: 1] == 1'b1 : m_busy)) m_gi = c;
            end
            if (m_gi >= 0 && m_gi < NREQ) begin
                e_ready[m_gi +: 1] = 1'b1;
                a = req_addr[19*m_gi +: 19];
                m_inr = (int'(a) < DEPTH);
                if (m_inr) begin
                    e_en = 1; e_we = req_we[m_gi +: 1]; e_addr = a;
                    e_wd = req_wdata[2*m_gi +: 2];
                end
            end else if (m_gi == NREQ) begin
                e_en = 1; e_we = 1; e_addr = 19'(m_cnt); e_wd = m_color;
            end
        end
        m_gnt = e_ready;
        chk("req_ready", req_ready, e_ready);
        chk("mem_en", mem_en, e_en);
        chk("mem_we", mem_we, e_we);
        chk("mem_addr", mem_addr, e_addr);
        chk("mem_wdata", mem_wdata, e_wd);
        chk("rsp_valid", rsp_valid, m_rsp);
        chk("rsp_data", rsp_data, (m_rsp != '0 && m_rsp_inr) ? mem_rdata : 2'b00);
        chk("pixel", pixel, m_pix);
        chk("clear_busy", clear_busy, m_busy);
    endtask

    // Clock edge: update the model with the outcome predicted this cycle
    task automatic advanceClock();
        @(posedge clk);
        if (m_disp_pend) m_pix = mem_rdata;
        m_disp_pend = disp_strobe;
        m_rsp = '0; m_rsp_inr = 0;
        if (m_gi >= 0 && m_gi < NREQ && req_we[m_gi +: 1] == 1'b0) begin
            m_rsp[m_gi +: 1] = 1'b1;
            m_rsp_inr = m_inr;
        end
        if (m_gi >= 0) m_ptr = (m_gi + 1) % NC;
        if (!m_busy) begin
            if (clear_start) begin m_busy = 1; m_cnt = 0; m_color = clear_color; end
        end else if (m_gi == NREQ) begin
            if (m_cnt == DEPTH - 1) m_busy = 0;
            else m_cnt++;
        end
        #1;
    endtask

    task automatic cycle();
        checkOutput();
        advanceClock();
    endtask

    // Hold reset with random inputs; every output must read zero
    task automatic applyReset();
        nReset = 0;
        disp_strobe = 1'($urandom); pixel_x = 10'($urandom_range(0, 639));
        pixel_y = 9'($urandom_range(0, 479));
        req_valid = NREQ'($urandom); req_we = NREQ'($urandom);
        req_addr = (NREQ*19)'($urandom); req_wdata = (NREQ*2)'($urandom);
        clear_start = 1'($urandom); clear_color = 2'($urandom); mem_rdata = 2'($urandom);
        #2;
        chk("rst_pixel", pixel, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_clear_busy", clear_busy, 0);
        chk("rst_mem", {mem_en, mem_we, mem_addr, mem_wdata}, 0);
        @(posedge clk); @(posedge clk); #1;
        setIdle();
        nReset = 1;
        modelReset();
    endtask

    // One cycle of random traffic; a waiting requester keeps its request
    task automatic applyStimulus();
        disp_strobe = ($urandom_range(0, 3) == 0);
        pixel_x = 10'($urandom_range(0, 639));
        pixel_y = 9'($urandom_range(0, 479));
        mem_rdata = 2'($urandom);
        clear_start = ($urandom_range(0, 299) == 0);
        clear_color = 2'($urandom);
        for (int i = 0; i < NREQ; i++) begin
            if (req_valid[i +: 1] == 1'b0 || m_gnt[i +: 1] == 1'b1) begin
                req_valid[i +: 1] = 1'($urandom_range(0, 1));
                req_we[i +: 1] = 1'($urandom);
                req_addr[19*i +: 19] = ($urandom_range(0, 7) == 0) ?
                    19'(DEPTH + $urandom_range(0, 500)) : 19'($urandom_range(0, DEPTH - 1));
                req_wdata[2*i +: 2] = 2'($urandom);
            end
        end
    endtask

    initial begin
        $display("[TB] fb_arbiter bench start");
        nReset = 0;
        setIdle();
        modelReset();
        #1;
        applyReset();

        // Display fetch latency: pixel visible two cycles after the strobe
        disp_strobe = 1; pixel_x = 0; pixel_y = 0;
        checkOutput();
        chk("disp00_addr", mem_addr, 0);
        advanceClock();
        disp_strobe = 0; mem_rdata = 2'b10;
        cycle();
        mem_rdata = 2'b00;
        checkOutput();
        chk("pixel_latency", pixel, 2'b10);
        advanceClock();

        // Address arithmetic at the corner and an interior point
        disp_strobe = 1; pixel_x = 639; pixel_y = 479;
        checkOutput();
        chk("addr_max", mem_addr, 307199);
        advanceClock();
        pixel_x = 5; pixel_y = 1;
        checkOutput();
        chk("addr_645", mem_addr, 645);
        advanceClock();

        // Display beats a pending write, which is served the next cycle
        setIdle();
        req_valid = 2'b01; req_we = 2'b01; req_addr[18:0] = 19'd100; req_wdata[1:0] = 2'b11;
        disp_strobe = 1;
        checkOutput();
        chk("prio_ready", req_ready, 2'b00);
        chk("prio_disp_rd", {mem_en, mem_we}, 2'b10);
        advanceClock();
        disp_strobe = 0;
        checkOutput();
        chk("prio_grant", req_ready, 2'b01);
        chk("prio_we", mem_we, 1);
        advanceClock();
        setIdle();

        // Fairness: two continuous requesters alternate; requester 1 reads
        applyReset();
        req_valid = 2'b11; req_we = 2'b01;
        req_addr[18:0] = 19'd10; req_addr[37:19] = 19'd20;
        for (int k = 0; k < 4; k++) begin
            mem_rdata = 2'($urandom);
            checkOutput();
            chk("rr_grant", req_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
            if (k > 0) chk("rr_rsp", rsp_valid, (k % 2 == 0) ? 2'b10 : 2'b00);
            advanceClock();
        end
        setIdle();

        // Out-of-range reads are granted but return zero without SRAM access
        for (int j = 0; j < 2; j++) begin
            req_valid = 2'b01; req_we = 2'b00;
            req_addr[18:0] = (j == 0) ? 19'(DEPTH) : 19'd307200;
            mem_rdata = 2'b11;
            checkOutput();
            chk("oor_ready", req_ready, 2'b01);
            chk("oor_mem_en", mem_en, 0);
            advanceClock();
            setIdle();
            mem_rdata = 2'b11;
            checkOutput();
            chk("oor_rsp_valid", rsp_valid, 2'b01);
            chk("oor_rsp_data", rsp_data, 2'b00);
            advanceClock();
        end
        setIdle();

        // Full clear on an idle bus
        applyReset();
        clear_start = 1; clear_color = 2'b11;
        cycle();
        clear_start = 0; clear_color = 2'b00;
        writes = 0; last_addr = -1; guard = 0;
        do begin
            checkOutput();
            if (mem_en === 1'b1 && mem_we === 1'b1) begin
                writes++;
                last_addr = int'(mem_addr);
            end
            advanceClock();
            guard++;
        end while (clear_busy === 1'b1 && guard < DEPTH + 20);
        chk("clear_timeout", (guard < DEPTH + 20), 1);
        chk("clear_writes", writes, DEPTH);
        chk("clear_last_addr", last_addr, DEPTH - 1);
        chk("clear_cycles", guard, DEPTH);
        cycle();

        // Reset during a clear aborts it and leaves the bus quiet
        applyReset();
        clear_start = 1; clear_color = 2'b01;
        cycle();
        clear_start = 0;
        repeat (50) cycle();
        nReset = 0;
        #1;
        chk("abort_busy", clear_busy, 0);
        chk("abort_mem_en", mem_en, 0);
        @(posedge clk); #1;
        nReset = 1;
        modelReset();
        writes = 0;
        repeat (30) begin
            checkOutput();
            if (mem_en === 1'b1 && mem_we === 1'b1) writes++;
            advanceClock();
        end
        chk("abort_no_writes", writes, 0);

        // Randomized mixed traffic
        applyReset();
        repeat (2000) begin
            applyStimulus();
            cycle();
        end
        setIdle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
